// File: rtl/lock_pkg.sv
// Shared display codes and attempt_guard state encoding for the combination-lock datapath.
package lock_pkg;

    localparam logic [4:0] SSD_L     = 5'b01011;
    localparam logic [4:0] SSD_TIRE  = 5'b10010;
    localparam logic [4:0] SSD_BLANK = 5'b10011;

    // Digit codes 0..9 are the BCD value with a leading zero bit.
    function automatic logic [4:0] ssd_digit(input logic [3:0] bcd);
        return {1'b0, bcd};
    endfunction

    // Code 2'b11 is unused and recovers to ARMED.
    typedef enum logic [1:0] {
        ARMED   = 2'b00,
        LOCKOUT = 2'b01,
        RELEASE = 2'b10
    } guard_state_e;

endpackage

// File: rtl/attempt_guard_if.sv
// Attempt/entry handshake and lockout status/display bus of attempt_guard.
interface attempt_guard_if;

    logic        try_valid;
    logic        try_ok;
    logic        enter_req;
    logic        enter_gnt;
    logic        locked_out;
    logic [3:0]  fail_cnt;
    logic [6:0]  remaining;
    logic        sec_tick;
    logic        ssd_ovr_valid;
    logic [19:0] ssd_ovr;

    modport master (
        output try_valid, try_ok, enter_req,
        input  enter_gnt, locked_out, fail_cnt, remaining, sec_tick,
               ssd_ovr_valid, ssd_ovr
    );

    modport slave (
        input  try_valid, try_ok, enter_req,
        output enter_gnt, locked_out, fail_cnt, remaining, sec_tick,
               ssd_ovr_valid, ssd_ovr
    );

endinterface

// File: rtl/sec_prescaler.sv
// Free-running 1 s prescaler with clear, sec_tick and half-period flag.
// Half-period flag is only built when ATTEMPT_GUARD_BLINK_EN is defined.
module sec_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic half
);

    localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

    logic [W-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

`ifdef ATTEMPT_GUARD_BLINK_EN
    assign half = (count >= W'(CLK_HZ / 2));
`else
    assign half = 1'b0;
`endif

endmodule

// File: rtl/attempt_guard.sv
// Failed-attempt lockout controller: counts wrong entries, locks out user entry and shows a countdown.
// Optional digit blink during lockout is enabled with ATTEMPT_GUARD_BLINK_EN.
module attempt_guard
    import lock_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int MAX_TRIES = 3,
    parameter int LOCK_SECS = 30
) (
    input logic            clk,
    input logic            rst,
    attempt_guard_if.slave bus
);

    guard_state_e state;
    logic [3:0]   fail_cnt;
    logic [6:0]   remaining;
    logic         locked_out;
    logic         tick;
    logic         half;
    logic         enter_lockout;
    logic [3:0]   tens;
    logic [3:0]   ones;
    logic         blank_digits;
    logic [19:0]  ssd;

    assign enter_lockout = (state == ARMED) && bus.try_valid && !bus.try_ok &&
                           (fail_cnt + 4'd1 == 4'(MAX_TRIES));

    sec_prescaler #(
        .CLK_HZ(CLK_HZ)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clear(enter_lockout),
        .tick (tick),
        .half (half)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARMED;
            fail_cnt   <= '0;
            remaining  <= '0;
            locked_out <= 1'b0;
        end else begin
            case (state)
                ARMED: begin
                    if (bus.try_valid) begin
                        if (bus.try_ok) begin
                            fail_cnt <= '0;
                        end else begin
                            fail_cnt <= fail_cnt + 4'd1;
                            if (enter_lockout) begin
                                state      <= LOCKOUT;
                                remaining  <= 7'(LOCK_SECS);
                                locked_out <= 1'b1;
                            end
                        end
                    end
                end
                LOCKOUT: begin
                    // A remaining of 0 here is unreachable; treating it as the last tick avoids underflow.
                    if (tick) begin
                        if (remaining <= 7'd1) begin
                            remaining  <= '0;
                            state      <= RELEASE;
                            locked_out <= 1'b0;
                        end else begin
                            remaining <= remaining - 7'd1;
                        end
                    end
                end
                RELEASE: begin
                    state     <= ARMED;
                    fail_cnt  <= '0;
                    remaining <= '0;
                end
                default: begin
                    state      <= ARMED;
                    fail_cnt   <= '0;
                    remaining  <= '0;
                    locked_out <= 1'b0;
                end
            endcase
        end
    end

    // Divide-by-10 as a constant compare chain; remaining never exceeds 99.
    always_comb begin
        tens = '0;
        for (int t = 1; t <= 9; t++) begin
            if (remaining >= 7'(t * 10)) begin
                tens = 4'(t);
            end
        end
        ones = 4'(remaining - 7'(tens) * 7'd10);
    end

    assign blank_digits = locked_out && half;

    always_comb begin
        ssd = {4{SSD_BLANK}};
        if (locked_out) begin
            ssd = {SSD_L, SSD_TIRE,
                   blank_digits ? SSD_BLANK : ssd_digit(tens),
                   blank_digits ? SSD_BLANK : ssd_digit(ones)};
        end
    end

    assign bus.enter_gnt     = bus.enter_req && (state == ARMED);
    assign bus.locked_out    = locked_out;
    assign bus.fail_cnt      = fail_cnt;
    assign bus.remaining     = remaining;
    assign bus.sec_tick      = tick;
    assign bus.ssd_ovr_valid = locked_out;
    assign bus.ssd_ovr       = ssd;

endmodule

// File: tb/tb_attempt_guard.sv
// Randomized self-checking bench for attempt_guard against a time-based lockout model.
// Define ATTEMPT_GUARD_BLINK_EN for both bench and RTL to check the digit blink.
module tb_attempt_guard;

    localparam int CLK_HZ    = 10;
    localparam int MAX_TRIES = 3;
    localparam int LOCK_SECS = 12;
    localparam int LOCK_CYC  = LOCK_SECS * CLK_HZ;

    logic clk = 1'b0;
    logic rst = 1'b1;

    attempt_guard_if bus();

    attempt_guard #(
        .CLK_HZ   (CLK_HZ),
        .MAX_TRIES(MAX_TRIES),
        .LOCK_SECS(LOCK_SECS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Model: cycle index since reset, prescaler zero point, lockout start cycle, failure count.
    int cyc;
    int base;
    int lock_start;
    int fails;
    bit lock_active;

    logic        exp_gnt;
    logic        exp_locked;
    logic        exp_tick;
    logic [3:0]  exp_fail;
    logic [6:0]  exp_rem;
    logic [19:0] exp_ssd;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [4:0] digit_code(input int d, input bit blank);
        return blank ? 5'b10011 : 5'(d);
    endfunction

    task automatic model_reset();
        cyc         = 0;
        base        = 0;
        lock_start  = 0;
        fails       = 0;
        lock_active = 0;
    endtask

    task automatic compute_expected(input logic er);
        int  phase;
        int  elapsed;
        int  rem;
        bit  blank;
        phase      = (cyc - base) % CLK_HZ;
        exp_tick   = (phase == CLK_HZ - 1);
        exp_locked = 1'b0;
        rem        = 0;
        if (lock_active) begin
            elapsed = cyc - lock_start;
            if (elapsed < LOCK_CYC) begin
                exp_locked = 1'b1;
                rem        = LOCK_SECS - elapsed / CLK_HZ;
            end
        end
        exp_rem  = 7'(rem);
        exp_fail = 4'(fails);
        exp_gnt  = er && !lock_active;
        blank    = 1'b0;
`ifdef ATTEMPT_GUARD_BLINK_EN
        blank = (phase >= CLK_HZ / 2);
`endif
        if (exp_locked)
            exp_ssd = {5'b01011, 5'b10010, digit_code(rem / 10, blank), digit_code(rem % 10, blank)};
        else
            exp_ssd = {4{5'b10011}};
    endtask

    task automatic step_model(input logic tv, input logic ok);
        if (lock_active) begin
            if (cyc - lock_start == LOCK_CYC) begin
                lock_active = 0;
                fails       = 0;
            end
        end else if (tv) begin
            if (ok) begin
                fails = 0;
            end else begin
                fails++;
                if (fails == MAX_TRIES) begin
                    lock_active = 1;
                    lock_start  = cyc + 1;
                    base        = cyc + 1;
                end
            end
        end
        cyc++;
    endtask

    task automatic compare_all(input string tag);
        check_output({tag, ".enter_gnt"}, 32'(bus.enter_gnt), 32'(exp_gnt));
        check_output({tag, ".locked_out"}, 32'(bus.locked_out), 32'(exp_locked));
        check_output({tag, ".fail_cnt"}, 32'(bus.fail_cnt), 32'(exp_fail));
        check_output({tag, ".remaining"}, 32'(bus.remaining), 32'(exp_rem));
        check_output({tag, ".sec_tick"}, 32'(bus.sec_tick), 32'(exp_tick));
        check_output({tag, ".ssd_ovr_valid"}, 32'(bus.ssd_ovr_valid), 32'(exp_locked));
        check_output({tag, ".ssd_ovr"}, 32'(bus.ssd_ovr), 32'(exp_ssd));
    endtask

    // Called at posedge+2: drive, check mid-cycle, then advance model across the next edge.
    task automatic apply_stimulus(input logic tv, input logic ok, input logic er);
        bus.try_valid = tv;
        bus.try_ok    = ok;
        bus.enter_req = er;
        #2;
        compute_expected(er);
        compare_all("cycle");
        @(posedge clk);
        step_model(tv, ok);
        #2;
    endtask

    task automatic async_reset();
        bus.try_valid = 1'b0;
        bus.try_ok    = 1'b0;
        bus.enter_req = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        compute_expected(1'b0);
        compare_all("async_reset");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        logic tv;
        logic ok;
        logic er;
        bus.try_valid = 1'b0;
        bus.try_ok    = 1'b0;
        bus.enter_req = 1'b0;
        #1 rst = 1'b0;
        #1;
        model_reset();
        compute_expected(1'b0);
        compare_all("reset");
        @(posedge clk);
        #2 rst = 1'b1;

        // Two failures, a success, then a failure coincident with enter_req.
        apply_stimulus(1'b1, 1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b1);
        check_output("fail_after_coincident", 32'(bus.fail_cnt), 32'd1);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_output("fail_after_success", 32'(bus.fail_cnt), 32'd0);

        // Full lockout with noise on try/enter, failing try on the release cycle.
        repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("lock_entry", 32'(bus.locked_out), 32'd1);
        check_output("lock_entry_ssd", 32'(bus.ssd_ovr), 32'({5'b01011, 5'b10010, 5'b00001, 5'b00010}));
        for (int i = 0; i < LOCK_CYC + 5; i++) begin
            tv = 1'b0;
            ok = 1'b0;
            er = 1'b0;
            if (lock_active && (cyc - lock_start == LOCK_CYC)) begin
                tv = 1'b1;
                er = 1'b1;
            end else if (lock_active) begin
                tv = 1'($urandom_range(0, 1));
                ok = 1'($urandom_range(0, 1));
                er = 1'($urandom_range(0, 1));
            end
            apply_stimulus(tv, ok, er);
        end
        check_output("after_release_fail", 32'(bus.fail_cnt), 32'd0);
        check_output("after_release_locked", 32'(bus.locked_out), 32'd0);

        // Asynchronous reset mid-lockout at remaining 7, then a granted entry.
        repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0);
        repeat ((LOCK_SECS - 7) * CLK_HZ + 3) apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("rem_before_reset", 32'(bus.remaining), 32'd7);
        async_reset();
        apply_stimulus(1'b0, 1'b0, 1'b1);

        // Randomized traffic including repeated lockouts.
        for (int i = 0; i < 1500; i++) begin
            tv = ($urandom_range(0, 3) == 0);
            ok = ($urandom_range(0, 2) == 0);
            er = 1'($urandom_range(0, 1));
            apply_stimulus(tv, ok, er);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
